arith_issue_arbiter: RTL

Round-robin issue arbiter that shares the single `arithmetic_pipeline` between up to `NUM_REQ` reservation-station requesters. Each cycle it grants at most one valid requester, latches the winning instruction packet into an issue register, and drives that register straight into the pipeline inputs. It sits between the arithmetic reservation stations and the pipeline. It also handles flush and issue-enable gating from the ROB/controller.

---
 rtl/arith_issue_arbiter_pkg.sv | 39 +++
 rtl/arith_issue_arbiter_if.sv | 36 +++
 rtl/arith_issue_arbiter_rr_picker.sv | 29 ++
 rtl/arith_issue_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/arith_issue_arbiter_pkg.sv
// Packet layout shared by the arithmetic reservation stations, issue arbiter and pipeline.
package arith_pkg;

  localparam int IMM_W       = 4;
  localparam int ARCH_W      = 8;
  localparam int FLAGS_VAL_W = 8;
  localparam int OPB_W       = 8;
  localparam int OPA_W       = 8;
  localparam int FLAG_REG_W  = 5;
  localparam int DEST_W      = 5;
  localparam int ROB_W       = 5;
  localparam int OPC_W       = 4;

  localparam int IMM_LSB       = 0;
  localparam int ARCH_LSB      = IMM_LSB + IMM_W;
  localparam int FLAGS_VAL_LSB = ARCH_LSB + ARCH_W;
  localparam int OPB_LSB       = FLAGS_VAL_LSB + FLAGS_VAL_W;
  localparam int OPA_LSB       = OPB_LSB + OPB_W;
  localparam int FLAG_REG_LSB  = OPA_LSB + OPA_W;
  localparam int DEST_LSB      = FLAG_REG_LSB + FLAG_REG_W;
  localparam int ROB_LSB       = DEST_LSB + DEST_W;
  localparam int OPC_LSB       = ROB_LSB + ROB_W;

  localparam int ARITH_PKT_W = OPC_LSB + OPC_W;

  // Declared MSB first so the packed struct lines up with the flattened bus.
  typedef struct packed {
    logic [OPC_W-1:0]       opcode;
    logic [ROB_W-1:0]       ROB_entry;
    logic [DEST_W-1:0]      dest_reg;
    logic [FLAG_REG_W-1:0]  flag_reg;
    logic [OPA_W-1:0]       op_a_val;
    logic [OPB_W-1:0]       op_b_val;
    logic [FLAGS_VAL_W-1:0] flags_val;
    logic [ARCH_W-1:0]      arch_dest_regs;
    logic [IMM_W-1:0]       immediate;
  } arith_pkt_t;

endpackage

// File: rtl/arith_issue_arbiter_if.sv
// Request/grant and issue-register bundle between reservation stations, arbiter and pipeline.
interface arith_issue_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import arith_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*ARITH_PKT_W-1:0] req_pkt;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           issue_en;
  logic                           flush;

  logic [3:0] opcode;
  logic [4:0] ROB_entry;
  logic [4:0] dest_reg;
  logic [4:0] flag_reg;
  logic [7:0] op_a_val;
  logic [7:0] op_b_val;
  logic [7:0] flags_val;
  logic [7:0] arch_dest_regs;
  logic [3:0] immediate;
  logic       instr_valid;

  modport master (
    output req_valid, req_pkt, issue_en, flush,
    input  req_ready, opcode, ROB_entry, dest_reg, flag_reg, op_a_val, op_b_val,
           flags_val, arch_dest_regs, immediate, instr_valid
  );

  modport slave (
    input  req_valid, req_pkt, issue_en, flush,
    output req_ready, opcode, ROB_entry, dest_reg, flag_reg, op_a_val, op_b_val,
           flags_val, arch_dest_regs, immediate, instr_valid
  );

endinterface

// File: rtl/arith_issue_arbiter_rr_picker.sv
// Combinational round-robin search: first valid requester at or after rr_ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   winner_idx_o,
  output logic               any_o
);

  always_comb begin
    grant_o      = '0;
    winner_idx_o = '0;
    any_o        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int s;
      s = int'(rr_ptr_i) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (!any_o && valid_i[s]) begin
        any_o        = 1'b1;
        winner_idx_o = PTR_W'(s);
        grant_o[s]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arith_issue_arbiter.sv
// Round-robin issue arbiter feeding the shared arithmetic pipeline from NUM_REQ stations.
// Optional ARITH_ARB_PERF_CNT_EN adds saturating grant/conflict counters.
module arith_issue_arbiter
  import arith_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  arith_issue_arbiter_if.slave  bus
`ifdef ARITH_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt,
  output logic [15:0]           conflict_cnt
`endif
);

  localparam int PKT_W = ARITH_PKT_W;
  localparam int PTR_W = $clog2(NUM_REQ);

  arith_pkt_t          req_pkts [NUM_REQ];
  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    win_idx;
  logic                any_vld;
  logic                gate_ok;
  logic                transfer;
  logic [NUM_REQ-1:0]  req_ready_w;

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  arith_pkt_t          pkt_q, pkt_d;
  logic                vld_q, vld_d;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_pkts[g] = bus.req_pkt[g*PKT_W +: PKT_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .valid_i      (bus.req_valid),
    .rr_ptr_i     (rr_ptr_q),
    .grant_o      (grant),
    .winner_idx_o (win_idx),
    .any_o        (any_vld)
  );

  // rst_n in the gate keeps req_ready low for the whole reset interval.
  assign gate_ok       = bus.issue_en & ~bus.flush & rst_n;
  assign transfer      = gate_ok & any_vld;
  assign req_ready_w   = gate_ok ? grant : '0;
  assign bus.req_ready = req_ready_w;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    pkt_d    = pkt_q;
    vld_d    = 1'b0;
    if (transfer) begin
      pkt_d    = req_pkts[win_idx];
      vld_d    = 1'b1;
      rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Issue register stage: grant cycle N -> pipeline inputs in cycle N+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      pkt_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pkt_q    <= pkt_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.opcode         = pkt_q.opcode;
  assign bus.ROB_entry      = pkt_q.ROB_entry;
  assign bus.dest_reg       = pkt_q.dest_reg;
  assign bus.flag_reg       = pkt_q.flag_reg;
  assign bus.op_a_val       = pkt_q.op_a_val;
  assign bus.op_b_val       = pkt_q.op_b_val;
  assign bus.flags_val      = pkt_q.flags_val;
  assign bus.arch_dest_regs = pkt_q.arch_dest_regs;
  assign bus.immediate      = pkt_q.immediate;
  assign bus.instr_valid    = vld_q;

`ifdef ARITH_ARB_PERF_CNT_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [15:0] conflict_cnt_q;
  logic        conflict;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign conflict = transfer && ($countones(bus.req_valid) > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] & req_ready_w[i]) grant_cnt_q[i] <= sat_inc(grant_cnt_q[i]);
      end
      if (conflict) conflict_cnt_q <= sat_inc(conflict_cnt_q);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*16 +: 16] = grant_cnt_q[g];
  end
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
